// File: rtl/click_pkg.sv
// Shared types and defaults for the click gesture decoder.
package click_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        LOCKOUT = 2'd2
    } click_state_t;

    localparam int unsigned WINDOW_DEFAULT     = 12_500_000;
    localparam int unsigned MAX_CLICKS_DEFAULT = 3;

    // Width needed to hold a gesture size of 0..max_clicks.
    function automatic int unsigned cnt_w(input int unsigned max_clicks);
        return $clog2(max_clicks + 1);
    endfunction

endpackage

// File: rtl/click_window_timer.sv
// Inter-press window down-counter: load restarts the window, en counts it down
// and the count holds at zero once the window has run out.
module click_window_timer
    import click_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = WINDOW_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned TMR_W = $clog2(WINDOW_CYCLES);

    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = TMR_W'(WINDOW_CYCLES - 1);
        end else if (en && (timer_q != '0)) begin
            timer_d = timer_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expired = (timer_q == '0);

endmodule

// File: rtl/click_decoder.sv
// Groups debounced key presses into single/double/triple... click gestures.
// Optional macro CLICK_DECODER_EARLY_EN reports a full gesture immediately and locks out.
module click_decoder
    import click_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = WINDOW_DEFAULT,
    parameter int unsigned MAX_CLICKS    = MAX_CLICKS_DEFAULT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               key_pulse,
    output logic                               click_valid,
    output logic [$clog2(MAX_CLICKS+1)-1:0]    click_count,
    output logic                               click_overflow
);

    localparam int unsigned      CNT_W   = cnt_w(MAX_CLICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CLICKS);

    click_state_t     state_q, state_d;
    logic             pulse_d_q, pulse_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_out_q, ovf_out_d;

    logic             press;
    logic [CNT_W-1:0] cnt_inc;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_expired;

    // A held-high pulse only counts on its first cycle.
    assign press   = key_pulse & ~pulse_d_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    click_window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        pulse_d_d = key_pulse;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        count_d   = count_q;
        ovf_out_d = ovf_out_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (press) begin
                    tmr_load = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = COUNT;
`ifdef CLICK_DECODER_EARLY_EN
                    if (CNT_MAX == CNT_W'(1)) begin
                        valid_d   = 1'b1;
                        count_d   = CNT_MAX;
                        ovf_out_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = LOCKOUT;
                    end
`endif
                end
            end

            COUNT: begin
                tmr_en = 1'b1;
                // A press on the expiry cycle extends the gesture instead of ending it.
                if (press) begin
                    tmr_load = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
`ifdef CLICK_DECODER_EARLY_EN
                        if (cnt_inc == CNT_MAX) begin
                            valid_d   = 1'b1;
                            count_d   = CNT_MAX;
                            ovf_out_d = 1'b0;
                            cnt_d     = '0;
                            ovf_d     = 1'b0;
                            state_d   = LOCKOUT;
                        end
`endif
                    end
                end else if (tmr_expired) begin
                    valid_d   = 1'b1;
                    count_d   = cnt_q;
                    ovf_out_d = ovf_q;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = IDLE;
                end
            end

`ifdef CLICK_DECODER_EARLY_EN
            LOCKOUT: begin
                tmr_en = 1'b1;
                if (press) begin
                    tmr_load = 1'b1;
                end else if (tmr_expired) begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pulse_d_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_d_q <= pulse_d_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign click_valid    = valid_q;
    assign click_count    = count_q;
    assign click_overflow = ovf_out_q;

endmodule

// File: tb/tb_click_decoder.sv
// Bench for click_decoder: directed gesture scenarios plus random presses/resets,
// every cycle compared against a deadline-based gesture model.
module tb_click_decoder;

    localparam int unsigned W  = 8;
    localparam int unsigned M  = 3;
    localparam int unsigned CW = $clog2(M + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          key_pulse = 1'b0;
    logic          click_valid;
    logic [CW-1:0] click_count;
    logic          click_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Gesture model: a gesture ends W edges after its last press edge.
    bit m_prev   = 1'b0;
    bit m_active = 1'b0;
    bit m_locked = 1'b0;
    int m_n      = 0;
    int m_last   = 0;
    int edge_no  = 0;
    bit e_valid  = 1'b0;
    int e_count  = 0;
    bit e_ovf    = 1'b0;

    int seen_valid      = 0;
    int last_count      = 0;
    int last_ovf        = 0;
    int last_valid_edge = 0;

    click_decoder #(
        .WINDOW_CYCLES (W),
        .MAX_CLICKS    (M)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .key_pulse      (key_pulse),
        .click_valid    (click_valid),
        .click_count    (click_count),
        .click_overflow (click_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, edge_no);
        end
    endtask

    task automatic step(input bit kp, input bit rst);
        bit press;
        reset     = rst;
        key_pulse = kp;
        @(posedge clk);
        edge_no++;
        if (rst) begin
            m_active = 1'b0;
            m_locked = 1'b0;
            m_n      = 0;
            m_prev   = 1'b0;
            e_valid  = 1'b0;
            e_count  = 0;
            e_ovf    = 1'b0;
        end else begin
            press   = kp && !m_prev;
            e_valid = 1'b0;
            if (press) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_locked = 1'b0;
                    m_n      = 1;
                end else if (!m_locked) begin
                    m_n++;
                end
                m_last = edge_no;
`ifdef CLICK_DECODER_EARLY_EN
                if (!m_locked && m_n == M) begin
                    e_valid  = 1'b1;
                    e_count  = M;
                    e_ovf    = 1'b0;
                    m_locked = 1'b1;
                end
`endif
            end else if (m_active && edge_no == m_last + W) begin
                if (!m_locked) begin
                    e_valid = 1'b1;
                    e_count = (m_n > M) ? M : m_n;
                    e_ovf   = (m_n > M);
                end
                m_active = 1'b0;
                m_locked = 1'b0;
                m_n      = 0;
            end
            m_prev = kp;
        end
        #1;
        check("click_valid", 32'(click_valid), 32'(e_valid));
        check("click_count", 32'(click_count), 32'(e_count));
        check("click_overflow", 32'(click_overflow), 32'(e_ovf));
        if (click_valid === 1'b1) begin
            seen_valid++;
            last_count      = int'(click_count);
            last_ovf        = int'(click_overflow);
            last_valid_edge = edge_no;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        int s0;
        int p_edge;
        bit kp;

        // Reset state
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle(6);

        // Single press
        s0 = seen_valid;
        step(1'b1, 1'b0);
        p_edge = edge_no;
        idle(W + 20);
        check("single_emits", 32'(seen_valid - s0), 32'd1);
        check("single_count", 32'(last_count), 32'd1);
        check("single_latency", 32'(last_valid_edge - p_edge), 32'(W));

        // Triple: presses 4 then 3 cycles apart
        s0 = seen_valid;
        step(1'b1, 1'b0); idle(3);
        step(1'b1, 1'b0); idle(2);
        step(1'b1, 1'b0);
        p_edge = edge_no;
        idle(W + 10);
        check("triple_emits", 32'(seen_valid - s0), 32'd1);
        check("triple_count", 32'(last_count), 32'd3);
        check("triple_latency", 32'(last_valid_edge - p_edge), 32'(W));

        // Five presses three cycles apart
        s0 = seen_valid;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
`ifdef CLICK_DECODER_EARLY_EN
            if (i == 2) p_edge = edge_no;
`else
            p_edge = edge_no;
`endif
            if (i < 4) idle(2);
        end
        idle(W + 10);
        check("five_emits", 32'(seen_valid - s0), 32'd1);
        check("five_count", 32'(last_count), 32'd3);
`ifdef CLICK_DECODER_EARLY_EN
        check("five_ovf", 32'(last_ovf), 32'd0);
        check("five_latency", 32'(last_valid_edge - p_edge), 32'd0);
`else
        check("five_ovf", 32'(last_ovf), 32'd1);
        check("five_latency", 32'(last_valid_edge - p_edge), 32'(W));
`endif

        // Second press lands exactly on the expiry cycle
        s0 = seen_valid;
        step(1'b1, 1'b0);
        idle(W - 1);
        step(1'b1, 1'b0);
        p_edge = edge_no;
        idle(W + 10);
        check("expiry_press_emits", 32'(seen_valid - s0), 32'd1);
        check("expiry_press_count", 32'(last_count), 32'd2);
        check("expiry_press_latency", 32'(last_valid_edge - p_edge), 32'(W));

        // key_pulse held for four cycles
        s0 = seen_valid;
        step(1'b1, 1'b0);
        p_edge = edge_no;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        idle(W + 10);
        check("held_emits", 32'(seen_valid - s0), 32'd1);
        check("held_count", 32'(last_count), 32'd1);
        check("held_latency", 32'(last_valid_edge - p_edge), 32'(W));

        // Reset mid-gesture discards it
        s0 = seen_valid;
        step(1'b1, 1'b0); idle(2);
        step(1'b1, 1'b0); idle(2);
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        idle(W + 10);
        check("reset_discard_emits", 32'(seen_valid - s0), 32'd0);
        step(1'b1, 1'b0);
        idle(W + 5);
        check("reset_after_emits", 32'(seen_valid - s0), 32'd1);
        check("reset_after_count", 32'(last_count), 32'd1);

        // key_pulse held through reset release counts as a press
        s0 = seen_valid;
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        p_edge = edge_no;
        step(1'b0, 1'b0);
        idle(W + 5);
        check("held_reset_emits", 32'(seen_valid - s0), 32'd1);
        check("held_reset_latency", 32'(last_valid_edge - p_edge), 32'(W));

        // Random presses, holds and occasional resets
        kp = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            kp = ($urandom_range(0, 6) == 0) || (kp && ($urandom_range(0, 2) == 0));
            step(kp, $urandom_range(0, 399) == 0);
        end
        idle(W + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
